// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
// Shared definitions for the parameterised serial sequence detector:
//   - MAX_PAT_LEN : widest pattern supported (8 bits)
//   - state_t     : control FSM states (S_IDLE, S_RUN)
//   - seg_code()  : progress digit to active-low {a,b,c,d,e,f,g} segment code
// -----------------------------------------------------------------------------
package seqdet_pkg;

    localparam int MAX_PAT_LEN = 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Digits above 8 cannot occur; they blank the display.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b0000001;
            4'd1:    code = 7'b1001111;
            4'd2:    code = 7'b0010010;
            4'd3:    code = 7'b0000110;
            4'd4:    code = 7'b1001100;
            4'd5:    code = 7'b0100100;
            4'd6:    code = 7'b0100000;
            4'd7:    code = 7'b0001111;
            4'd8:    code = 7'b0000000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seqdet_if.sv
// -----------------------------------------------------------------------------
// seqdet_if
// Data/control bundle of the sequence detector.
//   x         : serial data bit (sampled on ticks only)
//   pattern   : new pattern, bit PAT_LEN-1 is the first bit expected
//   pat_load  : one-clk strobe latching pattern
//   y         : one-clk match pulse
//   seg       : active-low 7-segment code of the progress digit
//   tick      : square wave toggling on every sample tick
//   match_cnt : number of matches (8-bit, wrapping)
// master = stimulus side, slave = detector side.
// -----------------------------------------------------------------------------
interface seqdet_if #(
    parameter int PAT_LEN = 4
);
    logic               x;
    logic [PAT_LEN-1:0] pattern;
    logic               pat_load;
    logic               y;
    logic [6:0]         seg;
    logic               tick;
    logic [7:0]         match_cnt;

    modport master (
        output x, pattern, pat_load,
        input  y, seg, tick, match_cnt
    );

    modport slave (
        input  x, pattern, pat_load,
        output y, seg, tick, match_cnt
    );
endinterface

// File: rtl/seqdet_tick_gen.sv
// -----------------------------------------------------------------------------
// seqdet_tick_gen
// Clock divider producing the sample strobe of the sequence detector.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   o_strobe : high for one clk while the divider sits at DIV_MAX-1
//   o_tick   : registered square wave, toggles on every strobe
// -----------------------------------------------------------------------------
module seqdet_tick_gen #(
    parameter int DIV_MAX = 20000000
) (
    input  logic clk,
    input  logic rst,
    output logic o_strobe,
    output logic o_tick
);

    localparam int CW = $clog2(DIV_MAX);

    logic [CW-1:0] r_div;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_div == CW'(DIV_MAX - 1));

    // Free-running divider that returns to zero in the strobe clock; tick follows it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= {CW{1'b0}};
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= {CW{1'b0}};
            r_tick <= ~r_tick;
        end else begin
            r_div  <= r_div + CW'(1);
            r_tick <= r_tick;
        end
    end

    assign o_strobe = w_wrap;
    assign o_tick   = r_tick;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector sampling x once per divided tick.
// Parameters:
//   PAT_LEN     : pattern length, 2..8
//   DEFAULT_PAT : pattern loaded at reset
//   OVERLAP     : 1 = overlapping matches, 0 = history cleared after a match
//   DIV_MAX     : system clocks per sample tick, >= 2
// Ports:
//   clk, rst    : system clock and synchronous active-high reset
//   bus (slave) : x, pattern, pat_load in; y, seg, tick, match_cnt out
// Build option:
//   SEQDET_MATCH_CNT_EN : when defined, match_cnt counts matches (wrapping);
//                         otherwise match_cnt is constant zero.
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b0001,
    parameter int                 OVERLAP     = 1,
    parameter int                 DIV_MAX     = 20000000
) (
    input  logic     clk,
    input  logic     rst,
    seqdet_if.slave  bus
);
    import seqdet_pkg::*;

    localparam int CNT_W = $clog2(MAX_PAT_LEN + 1);

    // True when the newest k history bits equal the first k pattern bits.
    function automatic logic prefix_ok(input logic [PAT_LEN-1:0] h,
                                       input logic [PAT_LEN-1:0] p,
                                       input int                 k);
        logic [PAT_LEN-1:0] mask;
        mask = (PAT_LEN'(1) << k) - PAT_LEN'(1);
        return ((h & mask) == (p >> (PAT_LEN - k)));
    endfunction

    logic               w_strobe;
    logic               w_tick;
    state_t             r_state;
    logic [PAT_LEN-1:0] r_pat;
    // Only the newest PAT_LEN-1 samples are stored: the oldest bit of the
    // window is shifted out by the same sample that would compare it.
    logic [PAT_LEN-2:0] r_hist;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_prog;
    logic               r_y;
    logic [6:0]         r_seg;

    logic [PAT_LEN-1:0] w_hist_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_prog_scan;
    logic [CNT_W-1:0]   w_prog_next;
    logic               w_sample;
    logic               w_match;

    seqdet_tick_gen #(
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .o_strobe (w_strobe),
        .o_tick   (w_tick)
    );

    // Post-shift view of the window: history, saturated count, match and progress
    always_comb begin
        w_hist_next = {r_hist, bus.x};
        w_cnt_next  = (r_cnt < CNT_W'(PAT_LEN)) ? (r_cnt + CNT_W'(1)) : r_cnt;
        w_sample    = w_strobe && !bus.pat_load && (r_state == S_RUN);
        w_match     = (w_cnt_next == CNT_W'(PAT_LEN)) && (w_hist_next == r_pat);
        w_prog_scan = {CNT_W{1'b0}};
        // Ascending scan keeps the largest qualifying prefix length
        for (int k = 1; k < PAT_LEN; k++) begin
            w_prog_scan = ((CNT_W'(k) <= w_cnt_next) && prefix_ok(w_hist_next, r_pat, k))
                          ? CNT_W'(k) : w_prog_scan;
        end
        w_prog_next = w_match ? CNT_W'(PAT_LEN) : w_prog_scan;
    end

    // Control FSM: pattern load, sampling, match pulse and progress register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= DEFAULT_PAT;
            r_hist  <= {(PAT_LEN-1){1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_prog  <= {CNT_W{1'b0}};
            r_y     <= 1'b0;
        end else if (bus.pat_load) begin
            // Load wins over a coincident strobe; that sample is dropped
            r_state <= S_RUN;
            r_pat   <= bus.pattern;
            r_hist  <= {(PAT_LEN-1){1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_prog  <= {CNT_W{1'b0}};
            r_y     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // First strobe after reset only arms the detector
                    r_state <= w_strobe ? S_RUN : S_IDLE;
                    r_y     <= 1'b0;
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    if (w_sample) begin
                        r_y    <= w_match;
                        r_prog <= w_prog_next;
                        if (w_match && (OVERLAP == 0)) begin
                            r_hist <= {(PAT_LEN-1){1'b0}};
                            r_cnt  <= {CNT_W{1'b0}};
                        end else begin
                            r_hist <= w_hist_next[PAT_LEN-2:0];
                            r_cnt  <= w_cnt_next;
                        end
                    end else begin
                        r_y <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_y     <= 1'b0;
                end
            endcase
        end
    end

    // Display register: progress digit decoded one clk after it changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'b0000001;
        end else begin
            r_seg <= seg_code(r_prog);
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [7:0] r_match_cnt;

    // Match counter, wraps from 255 to 0 through natural 8-bit overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= 8'd0;
        end else if (w_sample && w_match) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end else begin
            r_match_cnt <= r_match_cnt;
        end
    end

    assign bus.match_cnt = r_match_cnt;
`else
    assign bus.match_cnt = 8'd0;
`endif

    assign bus.y    = r_y;
    assign bus.seg  = r_seg;
    assign bus.tick = w_tick;

endmodule
